// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int UART_CLKS_PER_BIT = 50;
    localparam int UART_DATA_BITS    = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_byte_receiver_if.sv
// Byte-level output bundle of the UART receiver toward uart_controller.
// rx_valid and rx_framing_error are single-cycle strobes with no ready: the
// consumer must take rx_byte in the rx_valid cycle (it is also held until the next good byte).
interface uart_byte_receiver_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_byte;
    logic                      rx_valid;
    logic                      rx_framing_error;
    logic                      rx_busy;

    modport master (output rx_byte, output rx_valid, output rx_framing_error, output rx_busy);
    modport slave  (input  rx_byte, input  rx_valid, input  rx_framing_error, input  rx_busy);

endinterface

// File: rtl/uart_line_sync.sv
// Multi-stage synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic uart_rx_pin,
    output logic rxs
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_pin};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 oversampling UART receiver: 3-sample majority vote per bit, framing-error
// reporting and break hold-off. Returns to IDLE at mid-stop-bit.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 uart_rx_pin,
    uart_byte_receiver_if.master rx,
    output rx_state_t            dbg_state
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int MID = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_VOTE = CW'(MID + 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      rxs;
    rx_state_t                 state, state_n;
    logic [CW-1:0]             cnt, cnt_n;
    logic [2:0]                bit_idx, bit_idx_n;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_n;
    logic [UART_DATA_BITS-1:0] byte_q, byte_n;
    logic                      valid_q, valid_n;
    logic                      ferr_q, ferr_n;
    logic                      busy_q;
    logic                      samp_a, samp_b;
    logic                      vote_now, vote;

    uart_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clock       (clock),
        .reset_n     (reset_n),
        .uart_rx_pin (uart_rx_pin),
        .rxs         (rxs)
    );

    // The third vote sample is the live rxs in the decision cycle.
    assign vote_now = (cnt == CNT_VOTE);
    assign vote     = majority3(samp_a, samp_b, rxs);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
            byte_q    <= byte_n;
            valid_q   <= valid_n;
            ferr_q    <= ferr_n;
            busy_q    <= (state != IDLE);
            if (cnt == CNT_S0) samp_a <= rxs;
            if (cnt == CNT_S1) samp_b <= rxs;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        byte_n    = byte_q;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (vote_now) begin
                    if (!vote) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (vote_now) begin
                    shift_n = {vote, shift_reg[UART_DATA_BITS-1:1]};
                    if (bit_idx == LAST_BIT) state_n = STOP;
                    else                     bit_idx_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (vote_now) begin
                    if (vote) begin
                        byte_n  = shift_reg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                        cnt_n   = '0;
                    end
                end
            end
            BREAK: begin
                // cnt counts consecutive high clocks; any low sample restarts it.
                if (!rxs) begin
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign rx.rx_byte          = byte_q;
    assign rx.rx_valid         = valid_q;
    assign rx.rx_framing_error = ferr_q;
    assign rx.rx_busy          = busy_q;
    assign dbg_state           = state;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver: directed scenarios plus random frames, checked
// against an expected-event queue built from the frames the driver sends.
module tb_uart_byte_receiver;
    import uart_pkg::*;

    localparam int CPB     = UART_CLKS_PER_BIT;
    localparam int MID     = CPB / 2;
    localparam int LAT_NOM = 2 + 9 * CPB + MID + 2;

    logic      clock = 1'b0;
    logic      reset_n = 1'b0;
    logic      uart_rx_pin = 1'b1;
    rx_state_t dbg_state;

    uart_byte_receiver_if rx_if ();

    uart_byte_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .uart_rx_pin (uart_rx_pin),
        .rx          (rx_if.master),
        .dbg_state   (dbg_state)
    );

    // clock / reset block
    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    bit         prev_valid = 1'b0;
    logic [8:0] exp_q[$];      // bit 8 = framing error expected, [7:0] = byte
    int         exp_t[$];      // cycle of the start falling edge on the pin
    int         valid_times[$];
    logic [7:0] model_byte = 8'h00;
    logic [8:0] mon_e;
    int         mon_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // scoreboard: samples 1 time unit after each rising edge
    always @(posedge clock) begin
        #1;
        cyc++;
        if (mon_en) begin
            check("strobe_exclusive", 32'(rx_if.rx_valid & rx_if.rx_framing_error), 0);
            if (prev_valid) check("busy_after_valid", 32'(rx_if.rx_busy), 0);
            if (rx_if.rx_valid || rx_if.rx_framing_error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_t = exp_t.pop_front();
                    check("strobe_kind_ferr", 32'(rx_if.rx_framing_error), 32'(mon_e[8]));
                    if (!mon_e[8]) begin
                        check("byte_at_valid", 32'(rx_if.rx_byte), 32'(mon_e[7:0]));
                        model_byte = mon_e[7:0];
                    end
                    check("latency_window",
                          32'((cyc - mon_t >= LAT_NOM - 1) && (cyc - mon_t <= LAT_NOM + 1)), 1);
                end
                if (rx_if.rx_valid) valid_times.push_back(cyc);
            end
            check("rx_byte_hold", 32'(rx_if.rx_byte), 32'(model_byte));
            prev_valid = rx_if.rx_valid;
        end
    end

    // driver tasks (always entered on a falling edge)
    task automatic idle(input int n);
        uart_rx_pin = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int spike);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        exp_q.push_back({~stop, b});
        exp_t.push_back(cyc);
        for (int c = 0; c < 10 * CPB; c++) begin
            uart_rx_pin = f[c / CPB];
            if (c == spike) uart_rx_pin = ~uart_rx_pin;
            @(negedge clock);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        check("drain_in_time", 32'(exp_q.size()), 0);
        exp_q.delete();
        exp_t.delete();
    endtask

    initial begin
        int n;
        logic [7:0] rb;
        logic       rs;

        // reset
        reset_n = 1'b0;
        uart_rx_pin = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_valid", 32'(rx_if.rx_valid), 0);
        check("rst_ferr", 32'(rx_if.rx_framing_error), 0);
        check("rst_busy", 32'(rx_if.rx_busy), 0);
        check("rst_byte", 32'(rx_if.rx_byte), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;
        mon_en = 1'b1;
        idle(20);

        // 1: single good frame
        valid_times.delete();
        send_frame(8'hA5, 1'b1, -1);
        wait_drain(100);
        idle(5);
        check("t1_one_valid", 32'(valid_times.size()), 1);

        // 2: short low glitch on idle line
        idle(20);
        uart_rx_pin = 1'b0;
        repeat (10) @(negedge clock);
        check("t2_in_start", 32'(dbg_state), 32'(START));
        uart_rx_pin = 1'b1;
        n = 0;
        while (rx_if.rx_busy !== 1'b0 && n < 30) begin
            @(negedge clock);
            n++;
        end
        check("t2_busy_clear", 32'(rx_if.rx_busy), 0);
        idle(40);

        // 3: framing error, break, then recovery
        send_frame(8'h3C, 1'b0, -1);
        uart_rx_pin = 1'b0;
        repeat (100) @(negedge clock);
        check("t3_in_break", 32'(dbg_state), 32'(BREAK));
        check("t3_busy_break", 32'(rx_if.rx_busy), 1);
        wait_drain(10);
        uart_rx_pin = 1'b1;
        repeat (40) @(negedge clock);
        check("t3_hold_off", 32'(dbg_state), 32'(BREAK));
        repeat (20) @(negedge clock);
        check("t3_released", 32'(dbg_state), 32'(IDLE));
        send_frame(8'h3C, 1'b1, -1);
        wait_drain(100);

        // 4: back-to-back frames
        idle(10);
        valid_times.delete();
        send_frame(8'h01, 1'b1, -1);
        send_frame(8'h02, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        wait_drain(100);
        check("t4_count", 32'(valid_times.size()), 3);
        for (int i = 1; i < valid_times.size(); i++) begin
            n = valid_times[i] - valid_times[i-1];
            check("t4_gap", 32'((n >= 10 * CPB - 1) && (n <= 10 * CPB + 1)), 1);
        end

        // 5: one-clock spike at the middle sample of data bit 3
        idle(10);
        send_frame(8'h00, 1'b1, 4 * CPB + MID + 1);
        wait_drain(100);

        // 6: reset during bit 4 of 0x55, then 0x5A
        idle(10);
        valid_times.delete();
        for (int c = 0; c < 5 * CPB + MID; c++) begin
            uart_rx_pin = (c < CPB) ? 1'b0 : ((8'h55 >> ((c / CPB) - 1)) & 8'h01) != 0;
            @(negedge clock);
        end
        reset_n = 1'b0;
        model_byte = 8'h00;
        uart_rx_pin = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
        check("t6_rst_busy", 32'(rx_if.rx_busy), 0);
        idle(100);
        check("t6_no_strobe", 32'(valid_times.size()), 0);
        send_frame(8'h5A, 1'b1, -1);
        wait_drain(100);
        check("t6_one_valid", 32'(valid_times.size()), 1);

        // random frames, glitches and breaks
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                uart_rx_pin = 1'b0;
                repeat ($urandom_range(1, 12)) @(negedge clock);
                idle(40);
            end
            idle($urandom_range(0, 30));
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            send_frame(rb, rs, -1);
            if (!rs) begin
                uart_rx_pin = 1'b0;
                repeat ($urandom_range(0, 80)) @(negedge clock);
                idle(CPB + 10);
            end
        end
        idle(30);
        wait_drain(600);
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
        $fatal(1);
    end

endmodule
